alu_cc_pipe: RTL

Parametrised, two-stage pipelined Y86 integer ALU with valid/ready handshaking and an architectural condition-code register. It generalises the standalone fixed-function logic units to a configurable width. It executes ADD, SUB, AND and XOR with overflow, zero and sign detection. It sits between decode and write-back in the execute stage and owns CC state for conditional moves and jumps.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_core.sv | 42 ++++
 rtl/alu_cc_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the Y86 execute-stage ALU.
// Function codes, flag bundle and condition-code reset value.
package alu_pkg;

  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_XOR = 4'd3;

  typedef struct packed {
    logic of;
    logic zf;
    logic sf;
  } flags_t;

  localparam flags_t CC_RST = '{of: 1'b0, zf: 1'b1, sf: 1'b0};

endpackage

// File: rtl/alu_core.sv
// Combinational Y86 ALU: ADD/SUB/AND/XOR with OF/ZF/SF.
// Illegal function codes yield zero result, clear flags and raise err.
import alu_pkg::*;

module alu_core #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       fn,
  output logic [WIDTH-1:0] y,
  output flags_t           flags,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  always_comb begin
    y     = '0;
    flags = '0;
    err   = 1'b0;
    unique case (1'b1)
      fn == FN_ADD: begin
        y        = b + a;
        flags.of = (a[MSB] == b[MSB]) && (y[MSB] != b[MSB]);
      end
      fn == FN_SUB: begin
        y        = b - a;
        flags.of = (a[MSB] != b[MSB]) && (y[MSB] != b[MSB]);
      end
      fn == FN_AND: y = b & a;
      fn == FN_XOR: y = b ^ a;
      default:      err = 1'b1;
    endcase
    // an errored beat reports ZF=0 even though y is zero
    if (!err) begin
      flags.zf = (y == '0);
      flags.sf = y[MSB];
    end
  end

endmodule

// File: rtl/alu_cc_pipe.sv
// Two-stage pipelined Y86 ALU with valid/ready handshake and CC register.
// CC register is built only when ALU_CC_EN is defined; otherwise cc_* read 0.
import alu_pkg::*;

module alu_cc_pipe #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_fn,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_of,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_err,
  output logic             cc_of,
  output logic             cc_zf,
  output logic             cc_sf
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_fn;
  logic             s1_set_cc;
  logic             s2_set_cc;
  logic             s2_free;

  logic [WIDTH-1:0] core_y;
  flags_t           core_flags;
  logic             core_err;
  flags_t           out_flags;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;

  assign out_of = out_flags.of;
  assign out_zf = out_flags.zf;
  assign out_sf = out_flags.sf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_fn     <= '0;
      s1_set_cc <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= in_a;
        s1_b      <= in_b;
        s1_fn     <= in_fn;
        s1_set_cc <= in_set_cc;
      end
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a    (s1_a),
    .b    (s1_b),
    .fn   (s1_fn),
    .y    (core_y),
    .flags(core_flags),
    .err  (core_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_flags <= '0;
      out_err   <= 1'b0;
      s2_set_cc <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y     <= core_y;
        out_flags <= core_flags;
        out_err   <= core_err;
        s2_set_cc <= s1_set_cc;
      end
    end
  end

`ifdef ALU_CC_EN
  flags_t cc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc <= CC_RST;
    end else if (out_valid && out_ready && s2_set_cc && !out_err) begin
      cc <= out_flags;
    end
  end

  assign cc_of = cc.of;
  assign cc_zf = cc.zf;
  assign cc_sf = cc.sf;
`else
  logic unused_set_cc;

  assign unused_set_cc = s2_set_cc;
  assign cc_of = 1'b0;
  assign cc_zf = 1'b0;
  assign cc_sf = 1'b0;
`endif

endmodule
